multi_channel_batch_bot_buffer: RTL and testbench

MULTI_CHANNEL_BATCH_BOT_BUFFER -- requirements
Module: multi_channel_batch_bot_buffer

---
 rtl/multi_channel_batch_bot_buffer_pkg.sv | 29 ++
 rtl/multi_channel_batch_bot_buffer_channel.sv | 66 ++++++
 rtl/multi_channel_batch_bot_buffer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_multi_channel_batch_bot_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_batch_bot_buffer_pkg.sv
// Shared definitions for the multi-channel batch bot buffer: parameter defaults,
// the closed-batch descriptor and the drain state machine encoding.
package multi_channel_batch_bot_buffer_pkg;

  localparam int NUM_CHANNELS_DEF          = 4;
  localparam int BOT_WIDTH_DEF             = 128;
  localparam int PERM_WIDTH_DEF            = 6;
  localparam int DEPTH_LOG2_DEF            = 9;
  localparam int BATCH_FIFO_DEPTH_LOG2_DEF = 5;
  localparam int MAX_BATCH_LOG2_DEF        = 6;
  localparam int SLOWDOWN_MARGIN_DEF       = 160;

  // Fields are sized for the largest legal configuration (16 channels).
  localparam int CH_FIELD_W   = 4;
  localparam int SIZE_FIELD_W = 16;

  typedef struct packed {
    logic [CH_FIELD_W-1:0]   channel;
    logic [SIZE_FIELD_W-1:0] size;
  } batch_desc_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE   = 2'd0,
    DRAIN_LOAD   = 2'd1,
    DRAIN_STREAM = 2'd2,
    DRAIN_FINISH = 2'd3
  } drain_state_e;

endpackage

// File: rtl/multi_channel_batch_bot_buffer_channel.sv
// Per-channel circular bot buffer: simple dual-port RAM with wrap-bit pointers,
// used/full status and a registered read port.
module batch_channel_buffer #(
  parameter int WIDTH      = 134,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic [DEPTH_LOG2:0] used,
  output logic                full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_INC = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    rd_data_q;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

  // Pointer advance on accepted write / issued read.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_INC;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array and read register; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = used[DEPTH_LOG2];
  assign rd_data = rd_data_q;

endmodule

// File: rtl/multi_channel_batch_bot_buffer.sv
// Multi-channel batch bot buffer: per-channel batch capture, round-robin close
// arbitration into a descriptor FIFO, and a drain FSM streaming whole batches out.
module multi_channel_batch_bot_buffer
  import multi_channel_batch_bot_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS          = NUM_CHANNELS_DEF,
  parameter int BOT_WIDTH             = BOT_WIDTH_DEF,
  parameter int PERM_WIDTH            = PERM_WIDTH_DEF,
  parameter int DEPTH_LOG2            = DEPTH_LOG2_DEF,
  parameter int BATCH_FIFO_DEPTH_LOG2 = BATCH_FIFO_DEPTH_LOG2_DEF,
  parameter int MAX_BATCH_LOG2        = MAX_BATCH_LOG2_DEF,
  parameter int SLOWDOWN_MARGIN       = SLOWDOWN_MARGIN_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS*BOT_WIDTH-1:0]    bots,
  input  logic [NUM_CHANNELS*PERM_WIDTH-1:0]   validBotsPermutes,
  input  logic [NUM_CHANNELS-1:0]              batchesDone,
  output logic [NUM_CHANNELS-1:0]              slowDownInputs,
  output logic [BOT_WIDTH-1:0]                 botOut,
  output logic [PERM_WIDTH-1:0]                validBotPermutesOut,
  output logic                                 botOutValid,
  output logic                                 batchFinished,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] batchFinishedChannel,
  input  logic                                 requestSlowDown,
  output logic                                 overflowError
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int FIFO_DEPTH = 1 << BATCH_FIFO_DEPTH_LOG2;
  localparam int ENTRY_W    = BOT_WIDTH + PERM_WIDTH;
  localparam int CH_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FW         = BATCH_FIFO_DEPTH_LOG2;
  localparam logic [MAX_BATCH_LOG2-1:0] MAX_BATCH = {MAX_BATCH_LOG2{1'b1}};
  localparam logic [FW:0] FIFO_INC = {{FW{1'b0}}, 1'b1};

  logic [NUM_CHANNELS-1:0]   wr_req_s, wr_ok_s, rd_en_s, buf_full_s;
  logic [DEPTH_LOG2:0]       buf_used_s [NUM_CHANNELS];
  logic [ENTRY_W-1:0]        rd_data_s  [NUM_CHANNELS];
  logic [MAX_BATCH_LOG2-1:0] close_size_s [NUM_CHANNELS];
  logic [MAX_BATCH_LOG2-1:0] count_q [NUM_CHANNELS], count_d [NUM_CHANNELS];
  logic [MAX_BATCH_LOG2-1:0] pend_size_q [NUM_CHANNELS], pend_size_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   pending_q, pending_d;
  logic [NUM_CHANNELS-1:0]   slow_q, slow_d;
  logic                      overflow_q, overflow_d;
  logic                      init_q;

  logic                      grant_s;
  logic [CH_W-1:0]           grant_idx_s;
  logic [MAX_BATCH_LOG2-1:0] grant_size_s;
  logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;

  batch_desc_t               fifo_mem_q [FIFO_DEPTH];
  batch_desc_t               fifo_head_s, fifo_push_s;
  logic [FW:0]               fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d, fifo_used_s;
  logic                      fifo_full_s, fifo_empty_s;
  logic                      desc_unused_s;

  drain_state_e              state_q, state_d;
  logic [CH_W-1:0]           cur_ch_q, cur_ch_d;
  logic [SIZE_FIELD_W-1:0]   remaining_q, remaining_d;
  logic                      pop_s, issue_s, fin_sched_s;

  logic                      rd_v1_q, rd_v1_d;
  logic [CH_W-1:0]           rd_ch1_q, rd_ch1_d;
  logic                      out_valid_q, out_valid_d;
  logic [BOT_WIDTH-1:0]      bot_q, bot_d;
  logic [PERM_WIDTH-1:0]     mask_q, mask_d;
  logic                      fin_q, fin_d;
  logic [CH_W-1:0]           fin_ch_q, fin_ch_d;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    batch_channel_buffer #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok_s[g]),
      .wr_data ({bots[BOT_WIDTH*g +: BOT_WIDTH], validBotsPermutes[PERM_WIDTH*g +: PERM_WIDTH]}),
      .rd_en   (rd_en_s[g]),
      .rd_data (rd_data_s[g]),
      .used    (buf_used_s[g]),
      .full    (buf_full_s[g])
    );
  end

  assign fifo_used_s   = fifo_wr_q - fifo_rd_q;
  assign fifo_full_s   = fifo_used_s[FW];
  assign fifo_empty_s  = (fifo_used_s == '0);
  assign fifo_head_s   = fifo_mem_q[fifo_rd_q[FW-1:0]];
  assign desc_unused_s = ^fifo_head_s.channel;

  // Write acceptance, open-batch counting and close capture per channel.
  // A close refused because the previous one is still pending keeps its words
  // in the open count, so they ride along with the next close.
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      wr_req_s[i]     = |validBotsPermutes[PERM_WIDTH*i +: PERM_WIDTH];
      wr_ok_s[i]      = wr_req_s[i] && !buf_full_s[i] && (count_q[i] != MAX_BATCH);
      close_size_s[i] = count_q[i] + MAX_BATCH_LOG2'(wr_ok_s[i]);
      if (batchesDone[i] && !pending_q[i]) begin
        count_d[i]     = '0;
        pending_d[i]   = 1'b1;
        pend_size_d[i] = close_size_s[i];
      end else if (grant_s && (grant_idx_s == CH_W'(i))) begin
        count_d[i]     = close_size_s[i];
        pending_d[i]   = 1'b0;
        pend_size_d[i] = pend_size_q[i];
      end else begin
        count_d[i]     = close_size_s[i];
        pending_d[i]   = pending_q[i];
        pend_size_d[i] = pend_size_q[i];
      end
      overflow_d = overflow_d | (wr_req_s[i] & ~wr_ok_s[i]) | (batchesDone[i] & pending_q[i]);
      slow_d[i]  = !init_q
                   || ((DEPTH - int'(buf_used_s[i])) < SLOWDOWN_MARGIN)
                   || pending_q[i]
                   || (int'(fifo_used_s) >= FIFO_DEPTH - NUM_CHANNELS);
    end
  end

  // Round-robin close arbiter, searching from the channel after the last grant.
  always_comb begin
    grant_s      = 1'b0;
    grant_idx_s  = '0;
    grant_size_s = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CHANNELS) begin
        idx = idx - NUM_CHANNELS;
      end else begin
        idx = idx;
      end
      if (!grant_s && pending_q[idx] && !fifo_full_s) begin
        grant_s      = 1'b1;
        grant_idx_s  = CH_W'(idx);
        grant_size_s = pend_size_q[idx];
      end else begin
        grant_s = grant_s;
      end
    end
    if (grant_s) begin
      rr_ptr_d = (int'(grant_idx_s) == NUM_CHANNELS - 1) ? '0 : grant_idx_s + CH_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    fifo_push_s.channel = CH_FIELD_W'(grant_idx_s);
    fifo_push_s.size    = SIZE_FIELD_W'(grant_size_s);
    fifo_wr_d = grant_s ? fifo_wr_q + FIFO_INC : fifo_wr_q;
    fifo_rd_d = pop_s   ? fifo_rd_q + FIFO_INC : fifo_rd_q;
  end

  // Drain FSM: pop a descriptor, stream its words, then flag the batch end.
  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    remaining_d = remaining_q;
    pop_s       = 1'b0;
    issue_s     = 1'b0;
    fin_sched_s = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = DRAIN_LOAD;
        end else begin
          state_d = DRAIN_IDLE;
        end
      end
      DRAIN_LOAD: begin
        pop_s       = 1'b1;
        cur_ch_d    = fifo_head_s.channel[CH_W-1:0];
        remaining_d = fifo_head_s.size;
        if (fifo_head_s.size != '0) begin
          state_d = DRAIN_STREAM;
        end else begin
          state_d = DRAIN_FINISH;
        end
      end
      DRAIN_STREAM: begin
        if (!requestSlowDown) begin
          issue_s     = 1'b1;
          remaining_d = remaining_q - SIZE_FIELD_W'(1);
          if (remaining_q == SIZE_FIELD_W'(1)) begin
            state_d = DRAIN_FINISH;
          end else begin
            state_d = DRAIN_STREAM;
          end
        end else begin
          state_d = DRAIN_STREAM;
        end
      end
      DRAIN_FINISH: begin
        fin_sched_s = 1'b1;
        state_d     = DRAIN_IDLE;
      end
      default: begin
        state_d = DRAIN_IDLE;
      end
    endcase
  end

  // Two-stage read pipeline: RAM register, then output register.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rd_en_s[i] = issue_s && (cur_ch_q == CH_W'(i));
    end
    rd_v1_d     = issue_s;
    rd_ch1_d    = issue_s ? cur_ch_q : rd_ch1_q;
    out_valid_d = rd_v1_q;
    if (rd_v1_q) begin
      {bot_d, mask_d} = rd_data_s[rd_ch1_q];
    end else begin
      bot_d  = bot_q;
      mask_d = mask_q;
    end
    fin_d    = fin_sched_s;
    fin_ch_d = fin_sched_s ? cur_ch_q : fin_ch_q;
  end

  // Descriptor storage; only the pointers need clearing.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      fifo_mem_q[fifo_wr_q[FW-1:0]] <= fifo_push_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i]     <= '0;
        pend_size_q[i] <= '0;
      end
      pending_q   <= '0;
      slow_q      <= '1;
      overflow_q  <= 1'b0;
      init_q      <= 1'b0;
      rr_ptr_q    <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      state_q     <= DRAIN_IDLE;
      cur_ch_q    <= '0;
      remaining_q <= '0;
      rd_v1_q     <= 1'b0;
      rd_ch1_q    <= '0;
      out_valid_q <= 1'b0;
      bot_q       <= '0;
      mask_q      <= '0;
      fin_q       <= 1'b0;
      fin_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i]     <= count_d[i];
        pend_size_q[i] <= pend_size_d[i];
      end
      pending_q   <= pending_d;
      slow_q      <= slow_d;
      overflow_q  <= overflow_d;
      init_q      <= 1'b1;
      rr_ptr_q    <= rr_ptr_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      remaining_q <= remaining_d;
      rd_v1_q     <= rd_v1_d;
      rd_ch1_q    <= rd_ch1_d;
      out_valid_q <= out_valid_d;
      bot_q       <= bot_d;
      mask_q      <= mask_d;
      fin_q       <= fin_d;
      fin_ch_q    <= fin_ch_d;
    end
  end

  assign slowDownInputs       = slow_q;
  assign botOut               = bot_q;
  assign validBotPermutesOut  = mask_q;
  assign botOutValid          = out_valid_q;
  assign batchFinished        = fin_q;
  assign batchFinishedChannel = fin_ch_q;
  assign overflowError        = overflow_q;

endmodule

// File: tb/tb_multi_channel_batch_bot_buffer.sv
// Directed self-checking bench for multi_channel_batch_bot_buffer (default parameters).
module tb_multi_channel_batch_bot_buffer;

  localparam int NCH = 4;
  localparam int BW  = 128;
  localparam int PW  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*BW-1:0] bots;
  logic [NCH*PW-1:0] validBotsPermutes;
  logic [NCH-1:0]    batchesDone;
  logic [NCH-1:0]    slowDownInputs;
  logic [BW-1:0]     botOut;
  logic [PW-1:0]     validBotPermutesOut;
  logic              botOutValid;
  logic              batchFinished;
  logic [1:0]        batchFinishedChannel;
  logic              requestSlowDown;
  logic              overflowError;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] item_bot  [$];
  logic [PW-1:0] item_mask [$];
  int            fin_ch    [$];
  int            fin_idx   [$];
  int            fin_alone [$];

  always #5 clk = ~clk;

  multi_channel_batch_bot_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .bots                 (bots),
    .validBotsPermutes    (validBotsPermutes),
    .batchesDone          (batchesDone),
    .slowDownInputs       (slowDownInputs),
    .botOut               (botOut),
    .validBotPermutesOut  (validBotPermutesOut),
    .botOutValid          (botOutValid),
    .batchFinished        (batchFinished),
    .batchFinishedChannel (batchFinishedChannel),
    .requestSlowDown      (requestSlowDown),
    .overflowError        (overflowError)
  );

  // Output log, sampled on the falling edge.
  always @(negedge clk) begin
    if (botOutValid) begin
      item_bot.push_back(botOut);
      item_mask.push_back(validBotPermutesOut);
    end
    if (batchFinished) begin
      fin_ch.push_back(int'(batchFinishedChannel));
      fin_idx.push_back(item_bot.size());
      fin_alone.push_back(botOutValid ? 0 : 1);
    end
  end

  function automatic logic [BW-1:0] bot_of(input logic [15:0] v);
    return {8{v}};
  endfunction

  function automatic logic [PW-1:0] mask_of(input logic [15:0] v);
    return {v[4:0], 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bots              = '0;
    validBotsPermutes = '0;
    batchesDone       = '0;
  endtask

  task automatic clear_logs();
    item_bot.delete();
    item_mask.delete();
    fin_ch.delete();
    fin_idx.delete();
    fin_alone.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic put(input int ch, input logic [15:0] v);
    bots[BW*ch +: BW]              = bot_of(v);
    validBotsPermutes[PW*ch +: PW] = mask_of(v);
  endtask

  task automatic wr1(input int ch, input logic [15:0] v, input logic done);
    put(ch, v);
    batchesDone[ch] = done;
    step();
  endtask

  task automatic wait_fins(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (fin_ch.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 128'(fin_ch.size() >= n), 128'd1);
  endtask

  task automatic wait_items(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (item_bot.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 128'(item_bot.size() >= n), 128'd1);
  endtask

  task automatic chk_items(input string tag, input int start, input logic [15:0] base, input int n);
    logic [15:0] v;
    for (int k = 0; k < n; k++) begin
      v = base + 16'(k);
      if (start + k < item_bot.size()) begin
        chk({tag, "_bot"},  128'(item_bot[start + k]),  128'(bot_of(v)));
        chk({tag, "_mask"}, 128'(item_mask[start + k]), 128'(mask_of(v)));
      end else begin
        chk({tag, "_missing"}, 128'(item_bot.size()), 128'(start + n));
      end
    end
  endtask

  initial begin
    rst             = 1'b0;
    requestSlowDown = 1'b0;
    clear_in();
    repeat (3) step();
    chk("rst_valid", 128'(botOutValid), 128'd0);
    chk("rst_fin",   128'(batchFinished), 128'd0);
    chk("rst_ovf",   128'(overflowError), 128'd0);
    chk("rst_slow",  128'(slowDownInputs), 128'hF);
    rst = 1'b1;
    step();
    chk("slow_first_cycle", 128'(slowDownInputs), 128'hF);
    step();
    chk("slow_settled", 128'(slowDownInputs), 128'h0);

    // Single channel, close with the third write.
    clear_logs();
    wr1(0, 16'hA000, 1'b0);
    wr1(0, 16'hA001, 1'b0);
    wr1(0, 16'hA002, 1'b1);
    wait_fins(1, 40, "single_fin_timeout");
    chk("single_count", 128'(item_bot.size()), 128'd3);
    chk_items("single", 0, 16'hA000, 3);
    chk("single_fin_ch", 128'(fin_ch[0]), 128'd0);
    chk("single_fin_idx", 128'(fin_idx[0]), 128'd3);
    chk("single_fin_alone", 128'(fin_alone[0]), 128'd0);

    // Simultaneous closes on ch1 (2 words) and ch3 (1 word).
    clear_logs();
    put(1, 16'hB000);
    step();
    put(1, 16'hB001);
    put(3, 16'hC000);
    batchesDone = 4'b1010;
    step();
    wait_fins(2, 60, "dual_fin_timeout");
    chk("dual_count", 128'(item_bot.size()), 128'd3);
    chk_items("dual_ch1", 0, 16'hB000, 2);
    chk_items("dual_ch3", 2, 16'hC000, 1);
    chk("dual_fin0_ch", 128'(fin_ch[0]), 128'd1);
    chk("dual_fin1_ch", 128'(fin_ch[1]), 128'd3);
    chk("dual_fin0_idx", 128'(fin_idx[0]), 128'd2);
    chk("dual_fin1_idx", 128'(fin_idx[1]), 128'd3);

    // Zero-size close on ch2.
    clear_logs();
    batchesDone[2] = 1'b1;
    step();
    wait_fins(1, 40, "empty_fin_timeout");
    repeat (5) step();
    chk("empty_fin_ch", 128'(fin_ch[0]), 128'd2);
    chk("empty_fin_alone", 128'(fin_alone[0]), 128'd1);
    chk("empty_no_items", 128'(item_bot.size()), 128'd0);

    // Ten-word batch with a five-cycle downstream stall mid-stream.
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      wr1(0, 16'hD000 + 16'(k), (k == 9));
    end
    wait_items(3, 60, "stall_start_timeout");
    requestSlowDown = 1'b1;
    repeat (5) step();
    requestSlowDown = 1'b0;
    wait_fins(1, 80, "stall_fin_timeout");
    repeat (4) step();
    chk("stall_count", 128'(item_bot.size()), 128'd10);
    chk_items("stall", 0, 16'hD000, 10);
    chk("stall_fin_idx", 128'(fin_idx[0]), 128'd10);
    chk("stall_fin_alone", 128'(fin_alone[0]), 128'd0);
    chk("stall_fin_count", 128'(fin_ch.size()), 128'd1);

    // 63 words fill a batch; the 64th is dropped and the error sticks.
    clear_logs();
    for (int k = 0; k < 63; k++) begin
      wr1(1, 16'hE000 + 16'(k), 1'b0);
    end
    chk("ovf_before", 128'(overflowError), 128'd0);
    wr1(1, 16'hEEEE, 1'b0);
    chk("ovf_set", 128'(overflowError), 128'd1);
    batchesDone[1] = 1'b1;
    step();
    wait_fins(1, 200, "ovf_fin_timeout");
    chk("ovf_count", 128'(item_bot.size()), 128'd63);
    chk_items("ovf", 0, 16'hE000, 63);
    chk("ovf_fin_ch", 128'(fin_ch[0]), 128'd1);
    repeat (10) step();
    chk("ovf_sticky", 128'(overflowError), 128'd1);
    rst = 1'b0;
    step();
    step();
    chk("ovf_cleared", 128'(overflowError), 128'd0);
    chk("rst2_slow", 128'(slowDownInputs), 128'hF);
    rst = 1'b1;
    repeat (3) step();

    // Fill ch0 towards the slowdown margin with the drain stalled.
    clear_logs();
    requestSlowDown = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 63; k++) begin
        wr1(0, 16'(b * 63 + k), (k == 62));
      end
    end
    for (int k = 0; k < 36; k++) begin
      wr1(0, 16'(315 + k), 1'b0);
    end
    repeat (4) step();
    chk("margin_351_words", 128'(slowDownInputs), 128'h0);
    chk("margin_no_ovf", 128'(overflowError), 128'd0);
    wr1(0, 16'd351, 1'b0);
    wr1(0, 16'd352, 1'b0);
    step();
    chk("margin_353_words", 128'(slowDownInputs), 128'h1);

    // Reset while a batch is streaming discards everything in flight.
    requestSlowDown = 1'b0;
    wait_items(5, 40, "midreset_start_timeout");
    rst = 1'b0;
    step();
    clear_logs();
    rst = 1'b1;
    repeat (30) step();
    chk("midreset_items", 128'(item_bot.size()), 128'd0);
    chk("midreset_fins", 128'(fin_ch.size()), 128'd0);
    chk("midreset_slow", 128'(slowDownInputs), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
